// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate extender: extension-mode encoding.
package imm_ext_pkg;

    typedef logic [1:0] ext_mode_t;

    localparam ext_mode_t EXT_SIGN   = 2'b00;
    localparam ext_mode_t EXT_ZERO   = 2'b01;
    localparam ext_mode_t EXT_UPPER  = 2'b10;
    localparam ext_mode_t EXT_BRANCH = 2'b11;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: sign, zero, upper (LUI) and branch-offset modes.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  ext_mode_t        mode,
    output logic [OUT_W-1:0] data
);

    localparam int unsigned E = OUT_W - IN_W;

    logic [OUT_W-1:0] signExt;

    always_comb begin
        signExt = {{E{imm[IN_W-1]}}, imm};
        data    = signExt;
        unique case (mode)
            EXT_SIGN:   data = signExt;
            EXT_ZERO:   data = {{E{1'b0}}, imm};
            EXT_UPPER:  data = {imm, {E{1'b0}}};
            // Word offset: the two top sign bits fall off, no overflow reporting.
            EXT_BRANCH: data = signExt << 2;
            default:    data = signExt;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with valid/ready handshake and a 2-entry skid buffer.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  ext_mode_t        in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_neg
);

    if (IN_W < 2) begin : gBadInW
        $error("imm_extend_pipe: IN_W must be >= 2");
    end
    if (OUT_W < IN_W + 2) begin : gBadOutW
        $error("imm_extend_pipe: OUT_W must be >= IN_W+2");
    end

    logic [OUT_W-1:0] extData;

    imm_ext_core #(
        .IN_W (IN_W),
        .OUT_W(OUT_W)
    ) uCore (
        .imm (in_imm),
        .mode(in_mode),
        .data(extData)
    );

    logic             orValidQ, orValidD;
    logic             skValidQ, skValidD;
    logic [OUT_W-1:0] orDataQ, orDataD;
    logic [OUT_W-1:0] skDataQ, skDataD;
    logic             inReadyQ;
    logic             inXfer;
    logic             orLoad;

    assign inXfer = in_valid && inReadyQ;
    assign orLoad = !orValidQ || out_ready;

    // inReadyQ mirrors !skValidQ, so SK->OR and an input transfer never coincide.
    always_comb begin
        orValidD = orValidQ;
        orDataD  = orDataQ;
        skValidD = skValidQ;
        skDataD  = skDataQ;
        if (orLoad) begin
            if (skValidQ) begin
                orValidD = 1'b1;
                orDataD  = skDataQ;
                skValidD = 1'b0;
            end else if (inXfer) begin
                orValidD = 1'b1;
                orDataD  = extData;
            end else begin
                orValidD = 1'b0;
            end
        end else if (inXfer) begin
            skValidD = 1'b1;
            skDataD  = extData;
        end
    end

    // Separate ready register keeps in_ready low throughout reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            orValidQ <= 1'b0;
            orDataQ  <= '0;
            skValidQ <= 1'b0;
            skDataQ  <= '0;
            inReadyQ <= 1'b0;
        end else begin
            orValidQ <= orValidD;
            orDataQ  <= orDataD;
            skValidQ <= skValidD;
            skDataQ  <= skDataD;
            inReadyQ <= !skValidD;
        end
    end

    assign in_ready  = inReadyQ;
    assign out_valid = orValidQ;
    assign out_data  = orDataQ;
    assign out_neg   = orDataQ[OUT_W-1];

    skidNeverAlone: assert property (@(posedge clk) disable iff (rst) !(skValidQ && !orValidQ));

    outHeldWhileStalled: assert property (@(posedge clk) disable iff (rst)
        (orValidQ && !out_ready) |=> (orValidQ && $stable(orDataQ)));

endmodule
